mem_arbiter: RTL and testbench

Two-requester memory arbiter between the icache and the dcache and the single-ported RAM controller. Each cycle it grants the RAM to at most one cache. It drives the RAM request from the granted cache's signals and returns `ramload` and a per-cache wait. The dcache has priority. A starvation counter bounds how long an instruction fetch can wait. Sticky error and timeout flags are kept for the system monitor.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter sharing one single-ported RAM controller
// between the icache and the dcache. The dcache has priority, and a starvation
// counter bounds how long an instruction fetch can be held off. Sticky err and
// timeout flags are kept for the system monitor.
//
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   iREN, iaddr            icache read request and word address
//   iwait, iload           icache stall (low on its completing cycle) and read data
//   dREN, dWEN, daddr,     dcache read/write request, word address and write data
//   dstore
//   dwait, dload           dcache stall (low on its completing cycle) and read data
//   ramREN, ramWEN,        RAM strobes, address and write data
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err, timeout           sticky: ERROR seen under a grant / grant hit TIMEOUT
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255,
  parameter int CW         = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ram_st_t;

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [CW-1:0] TO_LIM     = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  ram_st_t       rs;
  logic          access;
  logic          dreq;
  logic          granted;
  logic [CW-1:0] wcnt_inc;

  assign rs      = ram_st_t'(ramstate);
  assign access  = (rs == RS_ACCESS);
  assign dreq    = dREN | dWEN;
  assign granted = (state_q != IDLE);

  assign err     = err_q;
  assign timeout = timeout_q;

  // Next-state and all cache/RAM outputs; every output is combinational from
  // the current state and inputs, there is no registered data path.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE: begin
        if (iREN && ((starve_q >= STARVE_LIM) || !dreq)) state_d = GNT_I;
        else if (dreq)                                    state_d = GNT_D;
      end
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !access;
        // Always return to IDLE after a word: one turnaround cycle per word.
        if (access || !iREN) state_d = IDLE;
      end
      GNT_D: begin
        ramREN   = dREN & !dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !access;
        if (access || !dreq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and sticky flags. ERROR does not end a grant; it counts as a
  // waiting cycle and the access is retried.
  always_comb begin
    wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;

    if (state_d == IDLE)        wcnt_d = '0;
    else if (granted && !access) wcnt_d = wcnt_inc;
    else                         wcnt_d = wcnt_q;

    timeout_d = timeout_q | (granted && !access && (wcnt_inc >= TO_LIM));
    err_d     = err_q | (granted && (rs == RS_ERROR));

    if (!iREN || ((state_q == GNT_I) && access)) starve_d = '0;
    else if (starve_q != '1)                     starve_d = starve_q + 1'b1;
    else                                         starve_d = starve_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenario tasks plus a randomized run, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam int TOUT = 8;
  localparam int CMAX = 255;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TOUT), .CW(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Reference model: owner 0 = nobody, 1 = icache, 2 = dcache.
  int m_own = 0, m_starve = 0, m_wcnt = 0;
  bit m_err = 0, m_to = 0;

  typedef struct {
    logic        ren, wen, iw, dw;
    logic [31:0] addr, store, il, dl;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e = '{ren: 1'b0, wen: 1'b0, iw: 1'b1, dw: 1'b1,
          addr: 32'h0, store: 32'h0, il: 32'h0, dl: 32'h0};
    if (m_own == 1) begin
      e.ren = iREN; e.addr = iaddr; e.il = ramload; e.iw = (ramstate != ACCESS);
    end else if (m_own == 2) begin
      e.ren = dREN && !dWEN; e.wen = dWEN; e.addr = daddr; e.store = dstore;
      e.dl = ramload; e.dw = (ramstate != ACCESS);
    end
    return e;
  endfunction

  task automatic model_tick();
    bit acc, dq;
    int nxt, inc;
    if (RST) begin
      m_own = 0; m_starve = 0; m_wcnt = 0; m_err = 0; m_to = 0;
      return;
    end
    acc = (ramstate == ACCESS);
    dq  = dREN || dWEN;
    if (m_own == 0) nxt = (iREN && (m_starve >= SMAX || !dq)) ? 1 : (dq ? 2 : 0);
    else if (m_own == 1) nxt = (acc || !iREN) ? 0 : 1;
    else nxt = (acc || !dq) ? 0 : 2;
    inc = (m_wcnt + 1 > CMAX) ? CMAX : m_wcnt + 1;
    if (m_own != 0 && !acc && inc >= TOUT) m_to = 1;
    if (m_own != 0 && ramstate == ERROR) m_err = 1;
    if (!iREN || (m_own == 1 && acc)) m_starve = 0;
    else if (m_starve < CMAX) m_starve++;
    if (nxt == 0) m_wcnt = 0;
    else if (m_own != 0 && !acc) m_wcnt = inc;
    m_own = nxt;
  endtask

  task automatic clk_step();
    @(posedge CLK);
    model_tick();
    #1;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1; iREN = 1; dREN = 1; dWEN = 0; ramstate = FREE;
    repeat (2) clk_step();
    sample();
    e = model_out();
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, err, timeout} !== 6'b110000) begin
      errors++;
      $display("FAIL reset: iwait,dwait,ren,wen,err,to=%b required 110000",
               {iwait, dwait, ramREN, ramWEN, err, timeout});
    end
    checks++;
    if ({ramREN, iwait, dwait} !== {e.ren, e.iw, e.dw}) begin
      errors++;
      $display("FAIL reset_model: got %b required %b", {ramREN, iwait, dwait}, {e.ren, e.iw, e.dw});
    end
    RST = 0; idle_inputs();
    clk_step();
  endtask

  task automatic test_single_fetch();
    logic [31:0] word;
    word = $urandom;
    iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = word;
    sample();
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      errors++; $display("FAIL fetch_c0: ren,iwait=%b required 01", {ramREN, iwait});
    end
    clk_step(); sample();
    checks++;
    if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'h40 || iload !== word) begin
      errors++;
      $display("FAIL fetch_c1: ren,iwait=%b addr=%h iload=%h required 10 00000040 %h",
               {ramREN, iwait}, ramaddr, iload, word);
    end
    clk_step(); idle_inputs(); sample();
    checks++;
    if ({ramREN, iwait} !== 2'b01 || iload !== 32'h0) begin
      errors++; $display("FAIL fetch_c2: ren,iwait=%b iload=%h required 01 0", {ramREN, iwait}, iload);
    end
    clk_step();
  endtask

  task automatic test_simultaneous();
    iREN = 1; iaddr = 32'h80; dWEN = 1; dREN = 0; daddr = 32'h3100; dstore = 32'hDEAD;
    ramstate = BUSY;
    sample();
    clk_step(); sample();
    checks++;
    if ({ramWEN, ramREN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h3100 || ramstore !== 32'hDEAD) begin
      errors++;
      $display("FAIL simul_dgrant: wen,ren,dw,iw=%b addr=%h store=%h required 1011 00003100 0000dead",
               {ramWEN, ramREN, dwait, iwait}, ramaddr, ramstore);
    end
    clk_step(); ramstate = ACCESS; sample();
    checks++;
    if ({dwait, iwait} !== 2'b01) begin
      errors++; $display("FAIL simul_dack: dw,iw=%b required 01", {dwait, iwait});
    end
    clk_step(); dWEN = 0; ramstate = FREE; sample();
    checks++;
    if ({ramWEN, ramREN} !== 2'b00) begin
      errors++; $display("FAIL simul_turn: wen,ren=%b required 00", {ramWEN, ramREN});
    end
    clk_step(); sample();
    checks++;
    if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h80 || ramstore !== 32'h0) begin
      errors++;
      $display("FAIL simul_igrant: ren,wen=%b addr=%h store=%h required 10 00000080 0",
               {ramREN, ramWEN}, ramaddr, ramstore);
    end
    clk_step(); ramstate = ACCESS; sample();
    checks++;
    if (iwait !== 1'b0) begin
      errors++; $display("FAIL simul_iack: iwait=%b required 0", iwait);
    end
    clk_step(); idle_inputs(); clk_step();
  endtask

  task automatic test_starvation();
    exp_t e;
    iREN = 1; iaddr = 32'h600; dREN = 1; dWEN = 0; daddr = 32'h500; ramstate = ACCESS;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) clk_step();
      sample();
      e = model_out();
      checks++;
      if (iwait !== (c != 5) || dwait !== !(c == 1 || c == 3)) begin
        errors++;
        $display("FAIL starve_c%0d: iwait,dwait=%b%b required %b%b", c, iwait, dwait,
                 (c != 5), !(c == 1 || c == 3));
      end
      checks++;
      if ({ramREN, ramaddr} !== {e.ren, e.addr}) begin
        errors++;
        $display("FAIL starve_model_c%0d: ren=%b addr=%h required %b %h", c, ramREN, ramaddr, e.ren, e.addr);
      end
    end
    idle_inputs(); clk_step();
  endtask

  task automatic test_error_timeout();
    int pulses = 0;
    dREN = 1; dWEN = 0; daddr = 32'h1230; ramstate = BUSY; ramload = 32'hCAFE0001;
    sample();
    for (int g = 0; g <= 11; g++) begin
      clk_step();
      ramstate = (g == 4) ? ERROR : ((g == 10) ? ACCESS : BUSY);
      if (g == 11) begin dREN = 0; ramstate = FREE; end
      sample();
      if (dwait === 1'b0) pulses++;
      checks++;
      if ({err, timeout, dwait, ramREN} !== {g >= 5, g >= 8, g != 10, g <= 10}) begin
        errors++;
        $display("FAIL errto_g%0d: err,to,dwait,ren=%b required %b", g,
                 {err, timeout, dwait, ramREN}, {g >= 5, g >= 8, g != 10, g <= 10});
      end
      if (g == 10) begin
        checks++;
        if (dload !== 32'hCAFE0001) begin
          errors++; $display("FAIL errto_dload: dload=%h required cafe0001", dload);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL errto_pulses: dwait low %0d cycles required 1", pulses);
    end
    idle_inputs(); clk_step();
  endtask

  task automatic test_abandon();
    iREN = 1; iaddr = 32'h200; dREN = 1; dWEN = 0; daddr = 32'h300; ramstate = BUSY;
    sample();
    for (int c = 1; c <= 6; c++) begin
      clk_step();
      if (c == 3) dREN = 0;
      if (c == 6) ramstate = ACCESS;
      sample();
      checks++;
      if (dwait !== 1'b1) begin
        errors++; $display("FAIL abandon_dwait_c%0d: dwait=%b required 1", c, dwait);
      end
      checks++;
      if (ramREN !== (c != 3 && c != 4) ||
          (c <= 2 && ramaddr !== 32'h300) || (c >= 5 && ramaddr !== 32'h200) ||
          iwait !== (c != 6)) begin
        errors++;
        $display("FAIL abandon_c%0d: ren=%b addr=%h iwait=%b", c, ramREN, ramaddr, iwait);
      end
    end
    idle_inputs(); clk_step();
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      clk_step();
      RST = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 3) iREN = $urandom;
      if ($urandom_range(0, 9) < 3) dREN = $urandom;
      if ($urandom_range(0, 9) < 2) dWEN = $urandom;
      if ($urandom_range(0, 9) < 3) iaddr = $urandom;
      if ($urandom_range(0, 9) < 3) daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      ramstate = ($urandom_range(0, 99) < 3) ? ERROR : 2'($urandom_range(0, 2));
      sample();
      e = model_out();
      checks++;
      if ({ramREN, ramWEN, ramaddr, ramstore} !== {e.ren, e.wen, e.addr, e.store}) begin
        errors++;
        $display("FAIL rand_ram_%0d: ren=%b wen=%b addr=%h store=%h required %b %b %h %h", n,
                 ramREN, ramWEN, ramaddr, ramstore, e.ren, e.wen, e.addr, e.store);
      end
      checks++;
      if ({iwait, dwait, iload, dload} !== {e.iw, e.dw, e.il, e.dl}) begin
        errors++;
        $display("FAIL rand_cache_%0d: iw=%b dw=%b il=%h dl=%h required %b %b %h %h", n,
                 iwait, dwait, iload, dload, e.iw, e.dw, e.il, e.dl);
      end
      checks++;
      if ({err, timeout} !== {m_err, m_to}) begin
        errors++;
        $display("FAIL rand_flags_%0d: err,to=%b required %b", n, {err, timeout}, {m_err, m_to});
      end
    end
    RST = 0; idle_inputs(); clk_step();
  endtask

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_error_timeout();
    test_abandon();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
